// File: rtl/pad_mux_pkg.sv
// pad_mux_pkg: shared address map, FSM state type and select-width helpers
// for the runtime-programmable pad multiplexer.
package pad_mux_pkg;

   localparam logic [7:0] OutSelBase = 8'h00;
   localparam logic [7:0] InSelBase  = 8'h80;
   localparam logic [7:0] LockAddr   = 8'hFF;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   // Width of an out_sel entry: encodes 0 (tie-off) plus one code per channel.
   function automatic int out_sel_w(input int n_peri_out);
      return $clog2(n_peri_out + 1);
   endfunction

   // Width of an in_sel entry: encodes 0 (read zero) plus one code per pad.
   function automatic int in_sel_w(input int n_pads);
      return $clog2(n_pads + 1);
   endfunction

endpackage

// File: rtl/pad_mux_sync.sv
// pad_mux_sync: vector two-flop synchroniser for the asynchronous pad inputs.
module pad_mux_sync #(
   parameter int Width = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] r_meta;
   logic [Width-1:0] r_sync;

   // Two back-to-back flops resolve metastability before the input mux.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/pad_mux.sv
// pad_mux: software-programmable peripheral<->pad multiplexer. Output
// reassignment drains the pad to high-Z before switching sources. The
// optional sticky configuration lock is enabled by defining PAD_MUX_LOCK_EN.
module pad_mux
   import pad_mux_pkg::*;
#(
   parameter int NPads       = 64,
   parameter int NPeriOut    = 32,
   parameter int NPeriIn     = 32,
   parameter int DrainCycles = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cfg_req_i,
   input  logic                cfg_we_i,
   input  logic [7:0]          cfg_addr_i,
   input  logic [31:0]         cfg_wdata_i,
   output logic                cfg_gnt_o,
   output logic                cfg_rvalid_o,
   output logic [31:0]         cfg_rdata_o,
   output logic                cfg_err_o,
   input  logic [NPeriOut-1:0] peri_out_i,
   input  logic [NPeriOut-1:0] peri_oe_i,
   output logic [NPeriIn-1:0]  peri_in_o,
   output logic [NPads-1:0]    pad_out_o,
   output logic [NPads-1:0]    pad_oe_o,
   input  logic [NPads-1:0]    pad_in_i,
   output logic                busy_o
);

   localparam int OSW = out_sel_w(NPeriOut);
   localparam int ISW = in_sel_w(NPads);
   localparam int OSN = 1 << OSW;
   localparam int ISN = 1 << ISW;
   localparam int PW  = (NPads > 1) ? $clog2(NPads) : 1;
   localparam int JW  = (NPeriIn > 1) ? $clog2(NPeriIn) : 1;
   localparam int CW  = $clog2(DrainCycles + 1);
   localparam logic [7:0]  NPadsL    = 8'(NPads);
   localparam logic [7:0]  NPeriInL  = 8'(NPeriIn);
   localparam logic [31:0] NPadsW    = 32'(NPads);
   localparam logic [31:0] NPeriOutW = 32'(NPeriOut);

   state_e         r_state, w_state_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic           w_commit;
   logic [OSW-1:0] r_out_sel [NPads];
   logic [ISW-1:0] r_in_sel  [NPeriIn];
   logic [PW-1:0]  r_pad;
   logic [OSW-1:0] r_new_sel;
   logic           r_rvalid, r_err;
   logic [31:0]    r_rdata;
   logic [NPads-1:0] w_sync;

   logic [6:0]     w_idx;
   logic [PW-1:0]  w_oidx;
   logic [JW-1:0]  w_jidx;
   logic           w_is_out, w_is_in, w_is_lock, w_locked;
   logic           w_err, w_wr_ok, w_out_wr, w_in_wr, w_drain_start;
   logic [OSW-1:0] w_wr_sel;
   logic [31:0]    w_rdata;
   logic [OSN-1:0] w_po_ext, w_oe_ext;
   logic [ISN-1:0] w_pi_ext;

   pad_mux_sync #(.Width(NPads)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (pad_in_i),
      .q_o   (w_sync)
   );

   assign busy_o    = (r_state == DRAIN);
   assign cfg_gnt_o = cfg_req_i & ~busy_o;

   // Address decode: out_sel window is 0x00-0x7F, in_sel window 0x80-0xFE.
   assign w_idx    = cfg_addr_i[6:0];
   assign w_oidx   = w_idx[PW-1:0];
   assign w_jidx   = w_idx[JW-1:0];
   assign w_is_out = ~cfg_addr_i[7] && ({1'b0, w_idx} < NPadsL);
   assign w_is_in  = cfg_addr_i[7] && (cfg_addr_i != LockAddr) && ({1'b0, w_idx} < NPeriInL);

`ifdef PAD_MUX_LOCK_EN
   logic r_lock;

   // Sticky lock: only reset clears it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_lock <= 1'b0;
      else if (w_wr_ok && w_is_lock && cfg_wdata_i[0]) r_lock <= 1'b1;
   end

   assign w_is_lock = (cfg_addr_i == LockAddr);
   assign w_locked  = r_lock;
`else
   assign w_is_lock = 1'b0;
   assign w_locked  = 1'b0;
`endif

   // Any error leaves state untouched; the lock register itself stays writable.
   assign w_err = ~(w_is_out | w_is_in | w_is_lock)
                | (cfg_we_i & w_is_out & (cfg_wdata_i > NPeriOutW))
                | (cfg_we_i & w_is_in  & (cfg_wdata_i > NPadsW))
                | (cfg_we_i & w_locked & ~w_is_lock);

   assign w_wr_ok       = cfg_gnt_o & cfg_we_i & ~w_err;
   assign w_out_wr      = w_wr_ok & w_is_out;
   assign w_in_wr       = w_wr_ok & w_is_in;
   assign w_wr_sel      = cfg_wdata_i[OSW-1:0];
   assign w_drain_start = w_out_wr & (w_wr_sel != r_out_sel[w_oidx]);

   // Read mux returns the committed value, zero-extended.
   always_comb begin
      w_rdata = '0;
      if (w_is_out)      w_rdata = 32'(r_out_sel[w_oidx]);
      else if (w_is_in)  w_rdata = 32'(r_in_sel[w_jidx]);
`ifdef PAD_MUX_LOCK_EN
      else if (w_is_lock) w_rdata = {31'd0, r_lock};
`endif
   end

   // FSM state and drain counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: a changing out_sel write drains for DrainCycles cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_drain_start) begin
               w_state_nxt = DRAIN;
               w_cnt_nxt   = CW'(DrainCycles);
            end
         end
         DRAIN: begin
            if (r_cnt == CW'(1)) begin
               w_state_nxt = IDLE;
               w_commit    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Pending reassignment; discarded by reset through the FSM state.
   always_ff @(posedge clk_i) begin
      if (w_drain_start) begin
         r_pad     <= w_oidx;
         r_new_sel <= w_wr_sel;
      end
   end

   // Select tables and bus response registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 0; p < NPads; p++) r_out_sel[p] <= '0;
         for (int j = 0; j < NPeriIn; j++) r_in_sel[j] <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         for (int p = 0; p < NPads; p++)
            if (w_commit && r_pad == PW'(p)) r_out_sel[p] <= r_new_sel;
         for (int j = 0; j < NPeriIn; j++)
            if (w_in_wr && w_jidx == JW'(j)) r_in_sel[j] <= cfg_wdata_i[ISW-1:0];
         r_rvalid <= cfg_gnt_o;
         r_err    <= cfg_gnt_o & w_err;
         r_rdata  <= (cfg_gnt_o && !w_err && !cfg_we_i) ? w_rdata : '0;
      end
   end

   assign cfg_rvalid_o = r_rvalid;
   assign cfg_err_o    = r_err;
   assign cfg_rdata_o  = r_rdata;

   // Code 0 of each select picks the zero slot at the bottom of the extended vectors.
   assign w_po_ext = OSN'({peri_out_i, 1'b0});
   assign w_oe_ext = OSN'({peri_oe_i, 1'b0});
   assign w_pi_ext = ISN'({w_sync, 1'b0});

   // Pad outputs follow out_sel; the draining pad is forced to high-Z.
   always_comb begin
      pad_out_o = '0;
      pad_oe_o  = '0;
      for (int p = 0; p < NPads; p++) begin
         if (!(busy_o && r_pad == PW'(p))) begin
            pad_out_o[p] = w_po_ext[r_out_sel[p]];
            pad_oe_o[p]  = w_oe_ext[r_out_sel[p]];
         end
      end
   end

   // Peripheral inputs select among the synchronised pads.
   always_comb begin
      peri_in_o = '0;
      for (int j = 0; j < NPeriIn; j++) peri_in_o[j] = w_pi_ext[r_in_sel[j]];
   end

endmodule

// File: tb/tb_pad_mux.sv
// tb_pad_mux: directed plus randomized checks of pad_mux against a behavioural
// model of the select tables, lock and drain timing.
module tb_pad_mux;

   localparam int NP = 64;
   localparam int NO = 32;
   localparam int NI = 32;
   localparam int DC = 2;
`ifdef PAD_MUX_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          cfg_req_i = 1'b0;
   logic          cfg_we_i = 1'b0;
   logic [7:0]    cfg_addr_i = '0;
   logic [31:0]   cfg_wdata_i = '0;
   logic          cfg_gnt_o, cfg_rvalid_o, cfg_err_o, busy_o;
   logic [31:0]   cfg_rdata_o;
   logic [NO-1:0] peri_out_i = '0;
   logic [NO-1:0] peri_oe_i = '0;
   logic [NI-1:0] peri_in_o;
   logic [NP-1:0] pad_out_o, pad_oe_o;
   logic [NP-1:0] pad_in_i = '0;

   always #5 clk_i = ~clk_i;

   pad_mux #(.NPads(NP), .NPeriOut(NO), .NPeriIn(NI), .DrainCycles(DC)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
      .cfg_wdata_i(cfg_wdata_i), .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o),
      .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
      .peri_out_i(peri_out_i), .peri_oe_i(peri_oe_i), .peri_in_o(peri_in_o),
      .pad_out_o(pad_out_o), .pad_oe_o(pad_oe_o), .pad_in_i(pad_in_i),
      .busy_o(busy_o)
   );

   int vectors = 0;
   int miscompares = 0;
   int m_out_sel [NP];
   int m_in_sel  [NI];
   bit m_lock;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic model_reset();
      foreach (m_out_sel[p]) m_out_sel[p] = 0;
      foreach (m_in_sel[j]) m_in_sel[j] = 0;
      m_lock = 1'b0;
   endtask

   function automatic logic [NP-1:0] exp_pad_out(input int force_pad);
      logic [NP-1:0] v = '0;
      for (int p = 0; p < NP; p++)
         if (p != force_pad && m_out_sel[p] != 0) v[p] = peri_out_i[m_out_sel[p]-1];
      return v;
   endfunction

   function automatic logic [NP-1:0] exp_pad_oe(input int force_pad);
      logic [NP-1:0] v = '0;
      for (int p = 0; p < NP; p++)
         if (p != force_pad && m_out_sel[p] != 0) v[p] = peri_oe_i[m_out_sel[p]-1];
      return v;
   endfunction

   // Valid only when pad_in_i has been stable for at least two clock edges.
   function automatic logic [NI-1:0] exp_peri_in();
      logic [NI-1:0] v = '0;
      for (int j = 0; j < NI; j++)
         if (m_in_sel[j] != 0) v[j] = pad_in_i[m_in_sel[j]-1];
      return v;
   endfunction

   function automatic bit model_err(input bit we, input int a, input longint d);
      bit mapped;
      if (a < 128)       mapped = (a < NP);
      else if (a == 255) mapped = LOCK_EN;
      else               mapped = (a - 128) < NI;
      if (!mapped) return 1'b1;
      if (we && m_lock && a != 255) return 1'b1;
      if (we && a < 128 && d > NO) return 1'b1;
      if (we && a >= 128 && a != 255 && d > NP) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int model_read(input int a);
      if (a < 128) return m_out_sel[a];
      if (a == 255) return int'(m_lock);
      return m_in_sel[a-128];
   endfunction

   // Low-level bus access: returns at grant+1 (response cycle), request dropped.
   task automatic cfg(input bit we, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int waits);
      cfg_req_i = 1'b1; cfg_we_i = we; cfg_addr_i = a; cfg_wdata_i = d;
      #1;
      waits = 0;
      while (!cfg_gnt_o && waits < 50) begin
         tick();
         waits++;
      end
      if (!cfg_gnt_o) begin
         chk("gnt_timeout", 1'b0, 1'b1);
         cfg_req_i = 1'b0;
         rd = '0; er = 1'b0;
         return;
      end
      tick();
      cfg_req_i = 1'b0;
      chk("rvalid", cfg_rvalid_o, 1'b1);
      rd = cfg_rdata_o;
      er = cfg_err_o;
   endtask

   // Full checked access including drain timing and model update.
   task automatic access(input bit we, input logic [7:0] a, input logic [31:0] d);
      logic [31:0] rd;
      logic er;
      int waits;
      bit e;
      int ai;
      ai = int'(a);
      e = model_err(we, ai, longint'(d));
      cfg(we, a, d, rd, er, waits);
      chk("err", er, e);
      if (!we) chk("rdata", rd, e ? 0 : model_read(ai));
      if (we && !e) begin
         if (ai < 128) begin
            if (int'(d) != m_out_sel[ai]) begin
               for (int c = 1; c <= DC; c++) begin
                  chk("drain_busy", busy_o, 1'b1);
                  chk("drain_oe", pad_oe_o, exp_pad_oe(ai));
                  chk("drain_out", pad_out_o, exp_pad_out(ai));
                  tick();
               end
               m_out_sel[ai] = int'(d);
            end
         end else if (ai == 255) begin
            m_lock = m_lock | d[0];
         end else begin
            m_in_sel[ai-128] = int'(d);
         end
      end
      chk("busy_idle", busy_o, 1'b0);
      chk("pad_oe", pad_oe_o, exp_pad_oe(-1));
      chk("pad_out", pad_out_o, exp_pad_out(-1));
      chk("peri_in", peri_in_o, exp_peri_in());
      tick();
      chk("rvalid_drop", cfg_rvalid_o, 1'b0);
   endtask

   initial begin
      logic [31:0] rd;
      logic er;
      int waits;
      logic [7:0] a;
      logic [31:0] d;
      bit we;
      int kind;

      model_reset();
      // Reset and idle outputs with every peripheral driving.
      #1 rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      peri_out_i = '1; peri_oe_i = '1; pad_in_i = '1;
      #1;
      chk("rst_pad_oe", pad_oe_o, '0);
      chk("rst_pad_out", pad_out_o, '0);
      chk("rst_peri_in", peri_in_o, '0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_rvalid", cfg_rvalid_o, 1'b0);
      chk("rst_rdata", cfg_rdata_o, '0);
      chk("rst_err", cfg_err_o, 1'b0);
      tick(); tick();

      // Drain write: out_sel[5] = 3 sources pad 5 from channel 2.
      peri_out_i = 32'hA5A5_0F0F;
      access(1'b1, 8'h05, 32'd3);
      chk("pad5_oe", pad_oe_o[5], 1'b1);
      chk("pad5_out", pad_out_o[5], peri_out_i[2]);
      peri_out_i[2] = ~peri_out_i[2];
      #1 chk("pad5_track", pad_out_o[5], peri_out_i[2]);
      access(1'b1, 8'h05, 32'd3);

      // Input path: in_sel[0] = 10 selects pad 9, two-edge latency.
      pad_in_i = '0;
      tick(); tick();
      access(1'b1, 8'h80, 32'd10);
      pad_in_i[9] = 1'b1;
      tick();
      chk("sync_1edge", peri_in_o[0], 1'b0);
      tick();
      chk("sync_2edge", peri_in_o[0], 1'b1);
      access(1'b1, 8'h80, NP + 1);
      access(1'b0, 8'h80, 32'd0);
      access(1'b1, 8'h40, 32'd1);
      access(1'b1, 8'hA0, 32'd1);
      access(1'b1, 8'h01, NO + 1);
      access(1'b1, 8'h01, NO);

      // Read during drain waits for busy to fall, then sees the new value.
      cfg(1'b1, 8'h06, 32'd4, rd, er, waits);
      chk("drn_wr_err", er, 1'b0);
      cfg(1'b0, 8'h06, 32'd0, rd, er, waits);
      chk("drn_rd_wait", waits, DC);
      chk("drn_rd_data", rd, 32'd4);
      chk("drn_rd_err", er, 1'b0);
      m_out_sel[6] = 4;
      tick();

      // Randomized accesses against the model.
      for (int it = 0; it < 60; it++) begin
         peri_out_i = $urandom;
         peri_oe_i = $urandom;
         pad_in_i = {$urandom, $urandom};
         tick(); tick();
         kind = $urandom_range(0, 9);
         we = $urandom_range(0, 1);
         if (kind < 4) begin
            a = 8'($urandom_range(0, NP - 1));
            d = $urandom_range(0, NO + 2);
         end else if (kind < 7) begin
            a = 8'(128 + $urandom_range(0, NI - 1));
            d = $urandom_range(0, NP + 2);
         end else begin
            a = 8'($urandom_range(0, 255));
            d = $urandom_range(0, 70);
         end
         if (a == 8'hFF) we = 1'b0;
         access(we, a, d);
      end

      // Lock register (unmapped when the lock is not built in).
      access(1'b1, 8'hFF, 32'd1);
      access(1'b1, 8'h00, 32'd1);
      access(1'b0, 8'hFF, 32'd0);
      access(1'b0, 8'h00, 32'd0);
`ifdef PAD_MUX_LOCK_EN
      chk("lock_set", m_lock, 1'b1);
`endif

      // Reset in the middle of a drain discards the pending select.
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      model_reset();
      peri_out_i = '1; peri_oe_i = '1;
      tick(); tick();
      cfg(1'b1, 8'h07, 32'd2, rd, er, waits);
      chk("p7_busy", busy_o, 1'b1);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_busy", busy_o, 1'b0);
      chk("mid_rst_oe", pad_oe_o, '0);
      chk("mid_rst_out", pad_out_o, '0);
      chk("mid_rst_peri_in", peri_in_o, '0);
      chk("mid_rst_rvalid", cfg_rvalid_o, 1'b0);
      tick();
      rst_i = 1'b0;
      tick(); tick();
      access(1'b0, 8'h07, 32'd0);
      access(1'b0, 8'hFF, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
